// File: rtl/store_buffer_fwd.sv
// store_buffer_fwd: parametrised store FIFO sitting between the LSU commit
// point and the D-cache write port. Provides valid/ready enqueue and drain,
// optional coalescing of a store into the youngest entry, and combinational
// store-to-load forwarding that distinguishes full hits from partial hits.

package store_buffer_fwd_pkg;
   typedef enum logic [1:0] {
      SIZE_BYTE = 2'd0,
      SIZE_HALF = 2'd1,
      SIZE_WORD = 2'd2
   } cache_access_size_t;
endpackage

module store_buffer_fwd
   import store_buffer_fwd_pkg::*;
#(
   parameter int NUM_ENTRIES = 4,
   parameter int ADDR_SIZE   = 32,
   parameter int WORD_SIZE   = 32,
   parameter bit COALESCE    = 1'b1
) (
   input  logic                           clk_i,
   input  logic                           reset_ni,
   input  logic                           put_valid_i,
   output logic                           put_ready_o,
   input  logic [ADDR_SIZE-1:0]           put_addr_i,
   input  logic [WORD_SIZE-1:0]           put_data_i,
   input  cache_access_size_t             put_size_i,
   output logic                           get_valid_o,
   input  logic                           get_ready_i,
   output logic [ADDR_SIZE-1:0]           get_addr_o,
   output logic [WORD_SIZE-1:0]           get_data_o,
   output logic [WORD_SIZE/8-1:0]         get_mask_o,
   input  logic [ADDR_SIZE-1:0]           lookup_addr_i,
   input  cache_access_size_t             lookup_size_i,
   output logic                           lookup_hit_o,
   output logic                           lookup_partial_o,
   output logic [WORD_SIZE-1:0]           lookup_data_o,
   output logic [$clog2(NUM_ENTRIES):0]   count_o
);

   localparam int BYTES = WORD_SIZE / 8;
   localparam int OFS   = $clog2(BYTES);
   localparam int IDX   = $clog2(NUM_ENTRIES);
   localparam int CNT   = IDX + 1;

   // Entry storage; kept in flops because forwarding reads every entry at once.
   logic [ADDR_SIZE-1:0] addr_reg [NUM_ENTRIES];
   logic [WORD_SIZE-1:0] data_reg [NUM_ENTRIES];
   logic [BYTES-1:0]     mask_reg [NUM_ENTRIES];
   logic [IDX-1:0]       head_reg, tail_reg, head_next, tail_next;
   logic [CNT-1:0]       count_reg, count_next;

   // Byte-enable pattern of an access at lane 0.
   function automatic logic [BYTES-1:0] size_mask(input cache_access_size_t s);
      logic [BYTES-1:0] m;
      m = '0;
      case (s)
         SIZE_BYTE: m[0]   = 1'b1;
         SIZE_HALF: m[1:0] = 2'b11;
         default:   m[3:0] = 4'hF;
      endcase
      return m;
   endfunction

   // ---------------- enqueue side ----------------
   logic [OFS-1:0]       put_ofs;
   logic [BYTES-1:0]     put_mask;
   logic [WORD_SIZE-1:0] put_data_sh, put_lane_data, merge_data;
   logic [ADDR_SIZE-1:0] put_word_addr;
   logic [IDX-1:0]       youngest_idx;
   logic                 put_fire, get_fire, merge, alloc;

   assign put_ofs       = put_addr_i[OFS-1:0];
   assign put_mask      = size_mask(put_size_i) << put_ofs;
   assign put_data_sh   = put_data_i << {put_ofs, 3'b000};
   assign put_word_addr = {put_addr_i[ADDR_SIZE-1:OFS], {OFS{1'b0}}};
   assign youngest_idx  = head_reg - IDX'(1);

   assign put_ready_o = (count_reg != CNT'(NUM_ENTRIES));
   assign get_valid_o = (count_reg != '0);
   assign put_fire    = put_valid_i & put_ready_o;
   assign get_fire    = get_valid_o & get_ready_i;

   // The youngest entry may only absorb a store if it is not leaving this cycle.
   assign merge = COALESCE && put_fire && (count_reg != '0) &&
                  (addr_reg[youngest_idx] == put_word_addr) &&
                  (!get_fire || (youngest_idx != tail_reg));
   assign alloc = put_fire && !merge;

   assign head_next  = head_reg + IDX'(alloc);
   assign tail_next  = tail_reg + IDX'(get_fire);
   assign count_next = count_reg + CNT'(alloc) - CNT'(get_fire);

   // Per-lane data for a fresh entry (unwritten lanes zero) and for a merge.
   genvar gi;
   generate
      for (gi = 0; gi < BYTES; gi++) begin : g_put_lane
         assign put_lane_data[8*gi +: 8] = put_mask[gi] ? put_data_sh[8*gi +: 8] : 8'h00;
         assign merge_data[8*gi +: 8]    = put_mask[gi] ? put_data_sh[8*gi +: 8]
                                                        : data_reg[youngest_idx][8*gi +: 8];
      end
   endgenerate

   // Pointer, count and entry update; merge and allocate are mutually exclusive.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         for (int i = 0; i < NUM_ENTRIES; i++) begin
            addr_reg[i] <= '0;
            data_reg[i] <= '0;
            mask_reg[i] <= '0;
         end
         head_reg  <= '0;
         tail_reg  <= '0;
         count_reg <= '0;
      end else begin
         if (alloc) begin
            addr_reg[head_reg] <= put_word_addr;
            data_reg[head_reg] <= put_lane_data;
            mask_reg[head_reg] <= put_mask;
         end
         if (merge) begin
            data_reg[youngest_idx] <= merge_data;
            mask_reg[youngest_idx] <= mask_reg[youngest_idx] | put_mask;
         end
         head_reg  <= head_next;
         tail_reg  <= tail_next;
         count_reg <= count_next;
      end
   end

   // ---------------- drain side ----------------
   assign get_addr_o = addr_reg[tail_reg];
   assign get_data_o = data_reg[tail_reg];
   assign get_mask_o = mask_reg[tail_reg];
   assign count_o    = count_reg;

   // ---------------- forwarding ----------------
   logic [ADDR_SIZE-1:0] lookup_word_addr;
   logic [OFS-1:0]       lookup_ofs;
   logic [BYTES-1:0]     req_mask, lane_cov, covered;
   logic [WORD_SIZE-1:0] lane_data, req_bits;
   logic [IDX-1:0]       age_idx [NUM_ENTRIES];
   logic [NUM_ENTRIES-1:0] age_match;

   assign lookup_ofs       = lookup_addr_i[OFS-1:0];
   assign lookup_word_addr = {lookup_addr_i[ADDR_SIZE-1:OFS], {OFS{1'b0}}};
   assign req_mask         = size_mask(lookup_size_i) << lookup_ofs;

   // age_idx[k] is the k-th oldest slot; only occupied slots may match.
   generate
      for (gi = 0; gi < NUM_ENTRIES; gi++) begin : g_age
         assign age_idx[gi]   = tail_reg + IDX'(gi);
         assign age_match[gi] = (CNT'(gi) < count_reg) &&
                                (addr_reg[age_idx[gi]] == lookup_word_addr);
      end
      for (gi = 0; gi < BYTES; gi++) begin : g_req_bits
         assign req_bits[8*gi +: 8] = {8{req_mask[gi]}};
      end
   endgenerate

   // Walk oldest to youngest so that younger matching bytes override older ones.
   always_comb begin
      lane_cov  = '0;
      lane_data = '0;
      for (int k = 0; k < NUM_ENTRIES; k++) begin
         if (age_match[k]) begin
            for (int b = 0; b < BYTES; b++) begin
               if (mask_reg[age_idx[k]][b]) begin
                  lane_cov[b]          = 1'b1;
                  lane_data[8*b +: 8]  = data_reg[age_idx[k]][8*b +: 8];
               end
            end
         end
      end
   end

   assign covered          = lane_cov & req_mask;
   assign lookup_hit_o     = (covered == req_mask);
   assign lookup_partial_o = (covered != '0) && !lookup_hit_o;
   assign lookup_data_o    = lookup_hit_o ? ((lane_data & req_bits) >> {lookup_ofs, 3'b000})
                                          : '0;

endmodule

// File: tb/tb_store_buffer_fwd.sv
// Self-checking bench for store_buffer_fwd: directed scenarios plus random
// traffic, checked by a queue-based reference model and a separate monitor.
module tb_store_buffer_fwd;
   import store_buffer_fwd_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic               reset_n;
   logic               put_valid, put_ready, get_valid, get_ready;
   logic [31:0]        put_addr, put_data, get_addr, get_data, lookup_addr, lookup_data;
   cache_access_size_t put_size, lookup_size;
   logic [3:0]         get_mask;
   logic               lookup_hit, lookup_partial;
   logic [2:0]         count;

   // outputs of the non-coalescing instance
   logic               ready0, gvalid0, hit0, part0;
   logic [31:0]        gaddr0, gdata0, ldata0;
   logic [3:0]         gmask0;
   logic [2:0]         count0;

   store_buffer_fwd #(.NUM_ENTRIES(4), .ADDR_SIZE(32), .WORD_SIZE(32), .COALESCE(1'b1)) dut (
      .clk_i(clk), .reset_ni(reset_n),
      .put_valid_i(put_valid), .put_ready_o(put_ready), .put_addr_i(put_addr),
      .put_data_i(put_data), .put_size_i(put_size),
      .get_valid_o(get_valid), .get_ready_i(get_ready), .get_addr_o(get_addr),
      .get_data_o(get_data), .get_mask_o(get_mask),
      .lookup_addr_i(lookup_addr), .lookup_size_i(lookup_size),
      .lookup_hit_o(lookup_hit), .lookup_partial_o(lookup_partial),
      .lookup_data_o(lookup_data), .count_o(count));

   store_buffer_fwd #(.NUM_ENTRIES(4), .ADDR_SIZE(32), .WORD_SIZE(32), .COALESCE(1'b0)) dut0 (
      .clk_i(clk), .reset_ni(reset_n),
      .put_valid_i(put_valid), .put_ready_o(ready0), .put_addr_i(put_addr),
      .put_data_i(put_data), .put_size_i(put_size),
      .get_valid_o(gvalid0), .get_ready_i(get_ready), .get_addr_o(gaddr0),
      .get_data_o(gdata0), .get_mask_o(gmask0),
      .lookup_addr_i(lookup_addr), .lookup_size_i(lookup_size),
      .lookup_hit_o(hit0), .lookup_partial_o(part0),
      .lookup_data_o(ldata0), .count_o(count0));

   typedef struct { logic [31:0] addr; logic [31:0] data; logic [3:0] mask; } ent_t;
   typedef struct { logic [2:0] cnt; logic put_ready; logic get_valid; } st_t;
   typedef struct { logic hit; logic partial; logic [31:0] data; } lk_t;

   ent_t mq[$];    // reference contents, oldest first
   ent_t g_q[$];   // expected drains
   st_t  st_q[$];  // expected status per cycle
   lk_t  lk_q[$];  // expected lookup per cycle

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic logic [3:0] smask(input cache_access_size_t s);
      case (s)
         SIZE_BYTE: return 4'h1;
         SIZE_HALF: return 4'h3;
         default:   return 4'hF;
      endcase
   endfunction

   function automatic int nbytes(input cache_access_size_t s);
      case (s)
         SIZE_BYTE: return 1;
         SIZE_HALF: return 2;
         default:   return 4;
      endcase
   endfunction

   // For each requested byte, search from the youngest stored entry downwards.
   function automatic void model_lookup(input logic [31:0] la, input cache_access_size_t ls,
                                        output logic h, output logic p, output logic [31:0] d);
      int ofs, n, got;
      logic found;
      logic [31:0] bytes;
      ofs = int'(la[1:0]);
      n = nbytes(ls);
      got = 0;
      bytes = 32'h0;
      for (int l = ofs; l < ofs + n; l++) begin
         found = 1'b0;
         for (int e = mq.size() - 1; e >= 0; e--) begin
            if (!found && mq[e].addr == (la & ~32'd3) && mq[e].mask[l]) begin
               bytes[8*l +: 8] = mq[e].data[8*l +: 8];
               found = 1'b1;
            end
         end
         if (found) got++;
      end
      h = (got == n);
      p = (got > 0) && (got < n);
      d = h ? (bytes >> (8 * ofs)) : 32'h0;
   endfunction

   // Drive one cycle of stimulus, record expectations, advance the model.
   task automatic cycle(input logic pv, input logic [31:0] pa, input logic [31:0] pd,
                        input cache_access_size_t ps, input logic gr,
                        input logic [31:0] la, input cache_access_size_t ls);
      st_t st;
      lk_t lk;
      ent_t ne, y;
      logic pf, gf, mg;
      int ofs, sz;
      @(negedge clk);
      put_valid = pv; put_addr = pa; put_data = pd; put_size = ps;
      get_ready = gr; lookup_addr = la; lookup_size = ls;
      sz = mq.size();
      st.cnt = 3'(sz); st.put_ready = (sz < 4); st.get_valid = (sz != 0);
      st_q.push_back(st);
      model_lookup(la, ls, lk.hit, lk.partial, lk.data);
      lk_q.push_back(lk);
      gf = gr && (sz != 0);
      pf = pv && (sz < 4);
      if (gf) g_q.push_back(mq[0]);
      ofs = int'(pa[1:0]);
      ne.addr = pa & ~32'd3;
      ne.mask = smask(ps) << ofs;
      ne.data = pd << (8 * ofs);
      mg = pf && (sz != 0) && (mq[sz-1].addr == ne.addr) && !(gf && sz == 1);
      if (mg) begin
         y = mq[sz-1];
         for (int b = 0; b < 4; b++)
            if (ne.mask[b]) y.data[8*b +: 8] = ne.data[8*b +: 8];
         y.mask = y.mask | ne.mask;
         mq[sz-1] = y;
      end
      if (gf) void'(mq.pop_front());
      if (pf && !mg) mq.push_back(ne);
   endtask

   task automatic put(input logic [31:0] a, input logic [31:0] d, input cache_access_size_t s);
      cycle(1'b1, a, d, s, 1'b0, a, s);
   endtask

   task automatic idle(input logic [31:0] la, input cache_access_size_t ls);
      cycle(1'b0, 32'h0, 32'h0, SIZE_BYTE, 1'b0, la, ls);
   endtask

   task automatic drain();
      cycle(1'b0, 32'h0, 32'h0, SIZE_BYTE, 1'b1, 32'h0, SIZE_BYTE);
   endtask

   // Asynchronous reset pulse placed between clock edges.
   task automatic do_reset();
      @(negedge clk);
      put_valid = 1'b0; get_ready = 1'b0;
      #3;
      reset_n = 1'b0;
      #1;
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_get_valid", 32'(get_valid), 32'd0);
      chk("rst_put_ready", 32'(put_ready), 32'd1);
      chk("rst_get_addr", get_addr, 32'h0);
      chk("rst_get_mask", 32'(get_mask), 32'h0);
      chk("rst_hit", 32'(lookup_hit), 32'd0);
      chk("rst_partial", 32'(lookup_partial), 32'd0);
      mq.delete(); g_q.delete(); st_q.delete(); lk_q.delete();
      @(negedge clk);
      #3;
      reset_n = 1'b1;
   endtask

   // Monitor: compares DUT outputs against queued expectations each cycle.
   initial begin
      st_t st;
      lk_t lk;
      ent_t e;
      forever begin
         @(negedge clk);
         #2;
         if (reset_n) begin
            if (st_q.size() > 0) begin
               st = st_q.pop_front();
               chk("count", 32'(count), 32'(st.cnt));
               chk("put_ready", 32'(put_ready), 32'(st.put_ready));
               chk("get_valid", 32'(get_valid), 32'(st.get_valid));
            end
            if (lk_q.size() > 0) begin
               lk = lk_q.pop_front();
               chk("lk_hit", 32'(lookup_hit), 32'(lk.hit));
               chk("lk_partial", 32'(lookup_partial), 32'(lk.partial));
               chk("lk_data", lookup_data, lk.data);
            end
            if (get_valid && get_ready) begin
               if (g_q.size() > 0) begin
                  e = g_q.pop_front();
                  $display("drain addr=0x%08h data=0x%08h mask=0x%h", get_addr, get_data, get_mask);
                  chk("drain_addr", get_addr, e.addr);
                  chk("drain_data", get_data, e.data);
                  chk("drain_mask", 32'(get_mask), 32'(e.mask));
               end else begin
                  checks++;
                  errors++;
                  $display("FAIL drain_unexpected: got addr 0x%08h expected no drain", get_addr);
               end
            end
         end
      end
   end

   initial begin
      cache_access_size_t rs, ls;
      logic [31:0] ra, rd, la;
      reset_n = 1'b1;
      put_valid = 1'b0; put_addr = '0; put_data = '0; put_size = SIZE_BYTE;
      get_ready = 1'b0; lookup_addr = '0; lookup_size = SIZE_BYTE;
      do_reset();

      // reset in the middle of operation
      put(32'h600, 32'h1, SIZE_WORD);
      put(32'h604, 32'h2, SIZE_WORD);
      put(32'h608, 32'h3, SIZE_WORD);
      idle(32'h600, SIZE_WORD);
      #3 chk("pre_rst_count", 32'(count), 32'd3);
      do_reset();

      // fill, hold-off, wrap, simultaneous put/get
      put(32'h100, 32'hA0, SIZE_WORD);
      put(32'h104, 32'hA1, SIZE_WORD);
      put(32'h108, 32'hA2, SIZE_WORD);
      put(32'h10C, 32'hA3, SIZE_WORD);
      put(32'h114, 32'hA4, SIZE_WORD);
      #3 chk("full_put_ready", 32'(put_ready), 32'd0);
      drain();
      #3 chk("drain0_addr", get_addr, 32'h100);
      put(32'h110, 32'hA5, SIZE_WORD);
      cycle(1'b1, 32'h110, 32'hEE, SIZE_WORD, 1'b1, 32'h110, SIZE_WORD);
      #3 chk("sim_full_drain_addr", get_addr, 32'h104);
      idle(32'h110, SIZE_WORD);
      #3 chk("sim_full_count", 32'(count), 32'd3);
      drain();
      #3 chk("drain1_addr", get_addr, 32'h108);
      drain();
      #3 chk("drain2_addr", get_addr, 32'h10C);
      cycle(1'b1, 32'h110, 32'h77, SIZE_BYTE, 1'b1, 32'h110, SIZE_BYTE);
      #3 chk("drain3_addr", get_addr, 32'h110);
      idle(32'h110, SIZE_WORD);
      #3 chk("tail_put_count", 32'(count), 32'd1);
      drain();
      #3 chk("tail_put_mask", 32'(get_mask), 32'h1);
      chk("tail_put_data", get_data, 32'h77);
      idle(32'h0, SIZE_BYTE);

      // coalescing versus always-allocate
      do_reset();
      put(32'h203, 32'hAA, SIZE_BYTE);
      put(32'h200, 32'hBBCC, SIZE_HALF);
      idle(32'h200, SIZE_WORD);
      #3 chk("coal_count", 32'(count), 32'd1);
      chk("nocoal_count", 32'(count0), 32'd2);
      drain();
      #3 chk("coal_addr", get_addr, 32'h200);
      chk("coal_mask", 32'(get_mask), 32'hB);
      chk("coal_data", get_data, 32'hAA00BBCC);

      // youngest-wins forwarding
      do_reset();
      put(32'h300, 32'h11223344, SIZE_WORD);
      put(32'h301, 32'h99, SIZE_BYTE);
      idle(32'h300, SIZE_WORD);
      #3 chk("fwd_word_hit", 32'(lookup_hit), 32'd1);
      chk("fwd_word_data", lookup_data, 32'h11229944);
      chk("fwd_word_data_nc", ldata0, 32'h11229944);
      idle(32'h302, SIZE_HALF);
      #3 chk("fwd_half_data", lookup_data, 32'h00001122);
      chk("fwd_half_data_nc", ldata0, 32'h00001122);

      // partial hit
      do_reset();
      put(32'h401, 32'h55, SIZE_BYTE);
      idle(32'h400, SIZE_WORD);
      #3 chk("part_hit", 32'(lookup_hit), 32'd0);
      chk("part_partial", 32'(lookup_partial), 32'd1);
      chk("part_data", lookup_data, 32'h0);
      idle(32'h402, SIZE_BYTE);
      #3 chk("miss_hit", 32'(lookup_hit), 32'd0);
      chk("miss_partial", 32'(lookup_partial), 32'd0);

      // random traffic over a small address window
      do_reset();
      for (int i = 0; i < 600; i++) begin
         rs = cache_access_size_t'($urandom_range(0, 2));
         ra = 32'h500 + 32'($urandom_range(0, 3) * 4);
         if (rs == SIZE_BYTE) ra = ra + 32'($urandom_range(0, 3));
         else if (rs == SIZE_HALF) ra = ra + 32'($urandom_range(0, 1) * 2);
         rd = $urandom;
         if (rs == SIZE_BYTE) rd = rd & 32'hFF;
         else if (rs == SIZE_HALF) rd = rd & 32'hFFFF;
         ls = cache_access_size_t'($urandom_range(0, 2));
         la = 32'h500 + 32'($urandom_range(0, 3) * 4);
         if (ls == SIZE_BYTE) la = la + 32'($urandom_range(0, 3));
         else if (ls == SIZE_HALF) la = la + 32'($urandom_range(0, 1) * 2);
         cycle(($urandom_range(0, 9) < 6), ra, rd, rs, ($urandom_range(0, 9) < 4), la, ls);
      end
      idle(32'h0, SIZE_BYTE);
      idle(32'h0, SIZE_BYTE);
      #3 chk("pending_drains", 32'(g_q.size()), 32'd0);
      chk("pending_status", 32'(st_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
